// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types for the multi-cycle instruction controller.
//   opcode_t    : 4-bit opcode encoding (OP_AND .. OP_HALT)
//   state_t     : controller sequencing states
//   op_class_t  : execution class an opcode belongs to
//   ctrl_word_t : registered control word produced in DECODE
//   class_word  : helper that expands a class into its control word
package ctrl_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'h0,
    OP_OR   = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_XOR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_CMP  = 4'h7,
    OP_MOV  = 4'h8,
    OP_BEQ  = 4'h9,
    OP_BNE  = 4'hA,
    OP_BLT  = 4'hB,
    OP_JMP  = 4'hC,
    OP_ST   = 4'hD,
    OP_LD   = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU = 3'd0,
    CL_CMP = 3'd1,
    CL_BR  = 3'd2,
    CL_JMP = 3'd3,
    CL_LD  = 3'd4,
    CL_ST  = 3'd5,
    CL_HLT = 3'd6,
    CL_NOP = 3'd7
  } op_class_t;

  typedef struct packed {
    op_class_t cls;
    logic      reg0_write;
    logic      gpr_write;
    logic      mem_to_reg;
    logic      write_mem;
  } ctrl_word_t;

  localparam ctrl_word_t CW_NOP = '{cls: CL_NOP, reg0_write: 1'b0, gpr_write: 1'b0,
                                    mem_to_reg: 1'b0, write_mem: 1'b0};

  // Only ALU results and loads reach the register file; both write the
  // accumulator and the addressed general-purpose register together.
  function automatic ctrl_word_t class_word(input op_class_t c);
    ctrl_word_t w;
    w.cls        = c;
    w.reg0_write = (c == CL_ALU) || (c == CL_LD);
    w.gpr_write  = (c == CL_ALU) || (c == CL_LD);
    w.mem_to_reg = (c == CL_LD);
    w.write_mem  = (c == CL_ST);
    return w;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: bundle between the controller and the core.
//   Start, Inst, MemReady, BranchTaken : core -> controller
//   strobes, IR, Done, Fault, InstCount: controller -> core
//   dbg_state                           : current controller state
// master = controller side, slave = core/datapath side.
//
// Handshakes: MemReq is the request (valid) and MemReady the completion
// (ready). MemReq stays high every MEM cycle with WriteMem stable until a
// cycle in which MemReady is also high; that cycle completes the access.
// MemReady is ignored when MemReq is low. Start is a level sampled only
// while idle or halted.
interface multicycle_control_if #(
  parameter int INST_W = 9,
  parameter int CNT_W  = 16
);
  logic              Start;
  logic [INST_W-1:0] Inst;
  logic              MemReady;
  logic              BranchTaken;

  logic              InstLoad;
  logic [INST_W-1:0] IR;
  logic              Reg0Write;
  logic              GenPurpRegWrite;
  logic              FlagWrite;
  logic              MemReq;
  logic              WriteMem;
  logic              MemToReg;
  logic              PcEn;
  logic              PcSrc;
  logic              Done;
  logic              Fault;
  logic [CNT_W-1:0]  InstCount;
  ctrl_pkg::state_t  dbg_state;

  modport master (
    input  Start, Inst, MemReady, BranchTaken,
    output InstLoad, IR, Reg0Write, GenPurpRegWrite, FlagWrite, MemReq,
           WriteMem, MemToReg, PcEn, PcSrc, Done, Fault, InstCount, dbg_state
  );

  modport slave (
    output Start, Inst, MemReady, BranchTaken,
    input  InstLoad, IR, Reg0Write, GenPurpRegWrite, FlagWrite, MemReq,
           WriteMem, MemToReg, PcEn, PcSrc, Done, Fault, InstCount, dbg_state
  );
endinterface

// File: rtl/inst_class_decoder.sv
// inst_class_decoder: purely combinational opcode -> control word mapping.
//   opcode : instruction opcode field (OPC_W bits, OPC_W >= 4)
//   cw     : control word for that opcode
// Opcodes above 4'hF (only possible when OPC_W > 4) are undefined and
// decode as NOP, which the controller retires straight out of EXEC.
module inst_class_decoder
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opcode,
  output ctrl_word_t       cw
);

  logic      defined;
  op_class_t cls;

  generate
    if (OPC_W > 4) begin : g_wide
      assign defined = ~|opcode[OPC_W-1:4];
    end else begin : g_narrow
      assign defined = 1'b1;
    end
  endgenerate

  always_comb begin
    cls = CL_NOP;
    if (defined) begin
      case (opcode_t'(opcode[3:0]))
        OP_AND, OP_OR, OP_ADD, OP_SUB,
        OP_XOR, OP_SHL, OP_SHR, OP_MOV: cls = CL_ALU;
        OP_CMP:                         cls = CL_CMP;
        OP_BEQ, OP_BNE, OP_BLT:         cls = CL_BR;
        OP_JMP:                         cls = CL_JMP;
        OP_ST:                          cls = CL_ST;
        OP_LD:                          cls = CL_LD;
        OP_HALT:                        cls = CL_HLT;
        default:                        cls = CL_NOP;
      endcase
    end
    cw = class_word(cls);
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle instruction sequencer.
//   Clk     : rising-edge clock
//   Reset_n : synchronous active-low reset
//   bus     : multicycle_control_if.master (instruction in, control
//             strobes, IR, Done/Fault, retired count, state out)
// Instructions step through FETCH/DECODE/EXEC[/MEM][/WB]. Strobes are
// decoded combinationally from the current state and the control word
// registered in DECODE. A retire cycle pulses PcEn, bumps InstCount and
// returns to FETCH. HALT parks in HALTED with Done; a memory access that
// waits MEM_TIMEOUT cycles parks in HALTED with Fault.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int INST_W      = 9,
  parameter int OPC_W       = 4,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input logic                 Clk,
  input logic                 Reset_n,
  multicycle_control_if.master bus
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t            state, next_state;
  logic [INST_W-1:0] ir;
  ctrl_word_t        cw, cw_dec;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  inst_count;
  logic              done, fault;

  logic inst_load, reg0_write, gpr_write, flag_write;
  logic mem_req, write_mem, mem_to_reg, pc_en, pc_src;
  logic retire, wait_inc, timed_out;
  logic set_done, set_fault, clr_flags, clr_count;

  inst_class_decoder #(.OPC_W(OPC_W)) u_dec (
    .opcode (ir[INST_W-1 -: OPC_W]),
    .cw     (cw_dec)
  );

  // A zero timeout disables the fault path entirely.
  assign timed_out = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT));

  always_comb begin
    next_state = state;
    inst_load  = 1'b0;
    reg0_write = 1'b0;
    gpr_write  = 1'b0;
    flag_write = 1'b0;
    mem_req    = 1'b0;
    write_mem  = 1'b0;
    mem_to_reg = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 1'b0;
    retire     = 1'b0;
    wait_inc   = 1'b0;
    set_done   = 1'b0;
    set_fault  = 1'b0;
    clr_flags  = 1'b0;
    clr_count  = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.Start) begin
          next_state = S_FETCH;
          clr_count  = 1'b1;
          clr_flags  = 1'b1;
        end
      end
      S_FETCH: begin
        inst_load  = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        // Decoder output is looked at directly here because cw is only
        // loaded at the end of this cycle.
        if (cw_dec.cls == CL_HLT) begin
          next_state = S_HALTED;
          set_done   = 1'b1;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cw.cls)
          CL_ALU:        next_state = S_WB;
          CL_CMP: begin
            flag_write = 1'b1;
            retire     = 1'b1;
          end
          CL_BR: begin
            pc_src = bus.BranchTaken;
            retire = 1'b1;
          end
          CL_JMP: begin
            pc_src = 1'b1;
            retire = 1'b1;
          end
          CL_LD, CL_ST:  next_state = S_MEM;
          default:       retire = 1'b1;  // undefined opcode: NOP
        endcase
      end
      S_MEM: begin
        mem_req   = 1'b1;
        write_mem = cw.write_mem;
        // Completion on the timeout cycle still counts as success.
        if (bus.MemReady) begin
          if (cw.cls == CL_ST) retire = 1'b1;
          else                 next_state = S_WB;
        end else if (timed_out) begin
          next_state = S_HALTED;
          set_fault  = 1'b1;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        reg0_write = cw.reg0_write;
        gpr_write  = cw.gpr_write;
        mem_to_reg = cw.mem_to_reg;
        retire     = 1'b1;
      end
      S_HALTED: begin
        // PC was never advanced past the HALT, so resuming re-fetches it.
        if (bus.Start) begin
          next_state = S_FETCH;
          clr_flags  = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase

    if (retire) begin
      pc_en      = 1'b1;
      next_state = S_FETCH;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      ir         <= '0;
      cw         <= CW_NOP;
      wait_cnt   <= '0;
      inst_count <= '0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state <= next_state;
      if (inst_load) ir <= bus.Inst;
      if (state == S_DECODE) cw <= cw_dec;
      // Counter only runs across consecutive stalled MEM cycles, so it is
      // already zero whenever a new access begins.
      wait_cnt <= wait_inc ? wait_cnt + 1'b1 : '0;
      if (clr_count)  inst_count <= '0;
      else if (pc_en) inst_count <= inst_count + 1'b1;
      if (clr_flags) begin
        done  <= 1'b0;
        fault <= 1'b0;
      end
      if (set_done)  done  <= 1'b1;
      if (set_fault) fault <= 1'b1;
    end
  end

  assign bus.InstLoad        = inst_load;
  assign bus.IR              = ir;
  assign bus.Reg0Write       = reg0_write;
  assign bus.GenPurpRegWrite = gpr_write;
  assign bus.FlagWrite       = flag_write;
  assign bus.MemReq          = mem_req;
  assign bus.WriteMem        = write_mem;
  assign bus.MemToReg        = mem_to_reg;
  assign bus.PcEn            = pc_en;
  assign bus.PcSrc           = pc_src;
  assign bus.Done            = done;
  assign bus.Fault           = fault;
  assign bus.InstCount       = inst_count;
  assign bus.dbg_state       = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: self-checking bench for multicycle_control.
// A second instance with a 2-bit retire counter shares every input with
// the main instance so counter wrap can be checked on the same stream.
module tb_multicycle_control;
  import ctrl_pkg::*;

  localparam int INST_W = 9;

  // strobe vector layout, MSB first
  localparam logic [10:0] V_NONE = 11'h000;
  localparam logic [10:0] V_IL   = 11'h400;
  localparam logic [10:0] V_R0   = 11'h200;
  localparam logic [10:0] V_GP   = 11'h100;
  localparam logic [10:0] V_FW   = 11'h080;
  localparam logic [10:0] V_MR   = 11'h040;
  localparam logic [10:0] V_WM   = 11'h020;
  localparam logic [10:0] V_M2R  = 11'h010;
  localparam logic [10:0] V_PE   = 11'h008;
  localparam logic [10:0] V_PS   = 11'h004;
  localparam logic [10:0] V_DN   = 11'h002;
  localparam logic [10:0] V_FT   = 11'h001;

  localparam logic [8:0] I_ADD  = 9'b0010_00011;
  localparam logic [8:0] I_LD   = 9'b1110_00010;
  localparam logic [8:0] I_ST   = 9'b1101_00100;
  localparam logic [8:0] I_BLT  = 9'b1011_00001;
  localparam logic [8:0] I_CMP  = 9'b0111_00101;
  localparam logic [8:0] I_JMP  = 9'b1100_00111;
  localparam logic [8:0] I_HALT = 9'b1111_00000;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  multicycle_control_if #(.INST_W(INST_W), .CNT_W(16)) bus ();
  multicycle_control_if #(.INST_W(INST_W), .CNT_W(2))  bus2 ();

  assign bus2.Start       = bus.Start;
  assign bus2.Inst        = bus.Inst;
  assign bus2.MemReady    = bus.MemReady;
  assign bus2.BranchTaken = bus.BranchTaken;

  multicycle_control #(.INST_W(INST_W), .OPC_W(4), .CNT_W(16), .MEM_TIMEOUT(8)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus.master)
  );

  multicycle_control #(.INST_W(INST_W), .OPC_W(4), .CNT_W(2), .MEM_TIMEOUT(8)) u_dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus2.master)
  );

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];
  logic [15:0] exp_count;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [10:0] obs_vec();
    return {bus.InstLoad, bus.Reg0Write, bus.GenPurpRegWrite, bus.FlagWrite,
            bus.MemReq, bus.WriteMem, bus.MemToReg, bus.PcEn, bus.PcSrc,
            bus.Done, bus.Fault};
  endfunction

  // ---------------- driver tasks ----------------
  // Entered at a falling edge: drive this cycle's inputs, compare strobes
  // against the next scoreboard entry, then move to the next falling edge.
  task automatic step(input logic [8:0] inst, input logic rdy, input logic bt,
                      input logic st, input string tag);
    logic [10:0] exp;
    bus.Inst        = inst;
    bus.MemReady    = rdy;
    bus.BranchTaken = bt;
    bus.Start       = st;
    #1;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty", tag);
      n_checks++;
    end else begin
      exp = exp_q.pop_front();
      check(tag, 32'(obs_vec()), 32'(exp));
    end
    @(negedge Clk);
  endtask

  // wait_k: MEM cycle (1-based) on which MemReady is raised; 0 = never.
  task automatic run_inst(input logic [8:0] inst, input int wait_k, input logic bt);
    logic [3:0] opc;
    logic       is_ld, is_st, rdy, bt_d;
    int         n_mem, total;
    opc   = inst[8:5];
    is_ld = (opc == 4'hE);
    is_st = (opc == 4'hD);
    exp_q.push_back(V_IL);
    exp_q.push_back(V_NONE);
    if (opc == 4'hF) begin
      // HALT: DECODE goes straight to HALTED
    end else if (is_ld || is_st) begin
      exp_q.push_back(V_NONE);
      n_mem = (wait_k == 0) ? 9 : wait_k;
      for (int i = 1; i <= n_mem; i++)
        exp_q.push_back(V_MR | (is_st ? V_WM : V_NONE) |
                        ((is_st && i == wait_k) ? V_PE : V_NONE));
      if (is_ld && wait_k != 0) exp_q.push_back(V_R0 | V_GP | V_M2R | V_PE);
    end else if (opc == 4'h7) begin
      exp_q.push_back(V_FW | V_PE);
    end else if (opc >= 4'h9 && opc <= 4'hB) begin
      exp_q.push_back(V_PE | (bt ? V_PS : V_NONE));
    end else if (opc == 4'hC) begin
      exp_q.push_back(V_PE | V_PS);
    end else begin
      exp_q.push_back(V_NONE);
      exp_q.push_back(V_R0 | V_GP | V_PE);
    end
    total = exp_q.size();
    for (int c = 0; c < total; c++) begin
      if ((is_ld || is_st) && c >= 3) rdy = (c == 2 + wait_k);
      else                            rdy = 1'($urandom_range(0, 1));
      bt_d = (c == 2) ? bt : 1'($urandom_range(0, 1));
      if (c == 1) check("ir", 32'(bus.IR), 32'(inst));
      step((c == 0) ? inst : 9'($urandom), rdy, bt_d, 1'b0, "strobes");
    end
    if (opc != 4'hF && !((is_ld || is_st) && wait_k == 0)) exp_count++;
    check("count", 32'(bus.InstCount), 32'(exp_count));
    check("count2", 32'(bus2.InstCount), 32'(exp_count[1:0]));
  endtask

  // Sit in HALTED for n cycles with flags v held; Start on the last one.
  task automatic halted(input logic [10:0] v, input int n);
    check("halted_state", 32'(bus.dbg_state), 32'(S_HALTED));
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v);
      step(9'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           (i == n - 1), "halted");
    end
    check("resume_state", 32'(bus.dbg_state), 32'(S_FETCH));
    check("resume_count", 32'(bus.InstCount), 32'(exp_count));
  endtask

  task automatic start_from_idle();
    check("idle_state", 32'(bus.dbg_state), 32'(S_IDLE));
    exp_q.push_back(V_NONE);
    step('0, 1'b0, 1'b0, 1'b1, "idle");
    exp_count = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, 32'(bus.dbg_state), 32'(S_IDLE));
    check({tag, "_strobes"}, 32'(obs_vec()), 32'(V_NONE));
    check({tag, "_count"}, 32'(bus.InstCount), 32'd0);
    check({tag, "_count2"}, 32'(bus2.InstCount), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] opc;
    bus.Start = 1'b0; bus.Inst = '0; bus.MemReady = 1'b0; bus.BranchTaken = 1'b0;
    Reset_n = 1'b0;
    exp_count = '0;
    repeat (2) @(negedge Clk);
    check_reset("rst");
    check("rst_ir", 32'(bus.IR), 32'd0);
    Reset_n = 1'b1;

    // three ADDs then HALT, resume
    start_from_idle();
    repeat (3) run_inst(I_ADD, 0, 1'b0);
    run_inst(I_HALT, 0, 1'b0);
    halted(V_DN, 3);

    // loads, stores, branches, compare, jump
    run_inst(I_LD, 3, 1'b0);
    run_inst(I_BLT, 0, 1'b1);
    run_inst(I_BLT, 0, 1'b0);
    run_inst(I_CMP, 0, 1'b0);
    run_inst(I_JMP, 0, 1'b0);
    run_inst(I_ST, 1, 1'b0);
    run_inst(I_LD, 1, 1'b0);
    run_inst(I_ST, 9, 1'b0);
    run_inst(I_LD, 9, 1'b0);

    // random ALU and branch mix
    for (int k = 0; k < 6; k++) begin
      opc = 4'($urandom_range(0, 7));
      if (opc == 4'h7) opc = 4'h8;
      run_inst({opc, 5'($urandom)}, 0, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      opc = 4'($urandom_range(9, 11));
      run_inst({opc, 5'($urandom)}, 0, 1'($urandom_range(0, 1)));
    end

    // store that never completes -> Fault, then resume
    run_inst(I_ST, 0, 1'b0);
    halted(V_FT, 3);
    run_inst(I_ADD, 0, 1'b0);

    // reset in the middle of a MEM wait
    exp_q.push_back(V_IL);
    exp_q.push_back(V_NONE);
    exp_q.push_back(V_NONE);
    exp_q.push_back(V_MR | V_WM);
    exp_q.push_back(V_MR | V_WM);
    step(I_ST, 1'b0, 1'b0, 1'b0, "rmem");
    for (int c = 1; c < 4; c++) step(9'($urandom), 1'b0, 1'b0, 1'b0, "rmem");
    Reset_n = 1'b0;
    step(9'($urandom), 1'b0, 1'b0, 1'b0, "rmem");
    check_reset("rmem");
    Reset_n = 1'b1;

    // five retires: 2-bit counter wraps to 1
    start_from_idle();
    repeat (5) run_inst(I_ADD, 0, 1'b0);
    check("wrap2", 32'(bus2.InstCount), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle, parametrised successor to the single-cycle opcode decoder. Latches each fetched instruction, decodes it into a registered control word, and sequences it through FETCH/DECODE/EXEC/MEM/WB. Each control strobe is asserted only in its stage. Adds a data-memory ready handshake with timeout, a branch-resolution input, retired-instruction counting and a halted/done state. Sits between instruction memory, register file, ALU and data memory in the top-level core.

Parameters:
INST_W, 9, instruction width in bits.
OPC_W, 4, opcode width; opcode = inst[INST_W-1 -: OPC_W].
CNT_W, 16, width of the retired-instruction counter.
MEM_TIMEOUT, 8, maximum MEM-state wait cycles before a fault; 0 disables the timeout.

Ports:
Clk  input  1  system clock, rising edge.
Reset_n  input  1  synchronous reset, active-low.
Start  input  1  begin or resume execution; sampled only in IDLE and HALTED.
Inst  input  INST_W  instruction memory output; valid during FETCH.
MemReady  input  1  data memory completed the current access.
BranchTaken  input  1  ALU flag-compare result for the current branch; valid in EXEC.
InstLoad  output  1  IR load strobe, high in FETCH.
IR  output  INST_W  latched instruction driven to the datapath.
Reg0Write  output  1  accumulator write strobe.
GenPurpRegWrite  output  1  general-purpose register write strobe.
FlagWrite  output  1  compare-flag write strobe (CMP).
MemReq  output  1  data memory access request.
WriteMem  output  1  store enable, qualified with MemReq.
MemToReg  output  1  writeback mux select, memory data.
PcEn  output  1  PC update strobe.
PcSrc  output  1  1 = branch target, 0 = PC+1; meaningful only with PcEn.
Done  output  1  in HALTED after a HALT instruction.
Fault  output  1  in HALTED after a memory timeout.
InstCount  output  CNT_W  number of retired instructions.

Behaviour:
- Reset (Reset_n=0 at an edge): state goes to IDLE; IR, InstCount and the wait counter clear to 0; all strobes, Done and Fault go to 0. This applies in any state; an in-flight MemReq drops the next cycle.
- Strobe outputs are combinational from the state and the registered control word. No strobe is high in IDLE or HALTED.
- IDLE: Start=1 moves to FETCH and clears InstCount and Fault.
- FETCH: InstLoad=1 and IR<=Inst; next state DECODE.
- DECODE: the control word is registered from IR's opcode class; next state is EXEC, or HALTED with Done<=1 for opcode 1111.
- EXEC, by class:
  - ALU (0000-0110, 1000): next state WB.
  - CMP (0111): FlagWrite=1 and retire.
  - Branch (1001-1011): PcSrc=BranchTaken and retire.
  - Jump (1100): PcSrc=1 and retire.
  - LOAD/STORE: next state MEM.
- MEM: MemReq=1 each cycle; WriteMem=1 for STORE. MemReady=1 ends the access:
  - STORE retires.
  - LOAD goes to WB.
  - MemReady=1 on the first MEM cycle gives zero wait.
- Memory timeout: the wait counter increments on each MEM cycle without MemReady. When the counter reaches MEM_TIMEOUT with MemReady=0, the next state is HALTED with Fault<=1. MemReady=1 on that same cycle wins: no fault.
- WB: Reg0Write=1 and GenPurpRegWrite=1; MemToReg=1 for LOAD; then retire.
- Retire means that cycle has PcEn=1, InstCount increments, and the next state is FETCH.
- InstCount wraps at 2^CNT_W-1 to 0. HALT does not retire.
- Latency per instruction:
  - ALU: 4 cycles.
  - CMP, branch, jump: 3 cycles.
  - STORE: 4+w cycles; LOAD: 5+w cycles, where w is the number of wait cycles.
  - HALT: 2 cycles to HALTED.
- HALTED: Done/Fault are held. Start=1 clears Done and Fault, keeps InstCount, and goes to FETCH. The PC is not advanced past HALT, so the datapath re-fetches the PC.
- Unknown opcodes are impossible at OPC_W=4. For wider OPC_W, undefined opcodes behave as a 3-cycle NOP and retire.

Decomposition:
- Package ctrl_pkg holds:
  - opcode enum (AND..HALT);
  - state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED);
  - op-class enum (ALU, CMP, BR, JMP, LD, ST, HLT, NOP);
  - packed struct ctrl_word_t (class, reg writes, mem_to_reg, write_mem).
- One combinational sub-module, inst_class_decoder, maps opcode to ctrl_word_t. The FSM, wait counter and InstCount stay in multicycle_control.

Test Plan:
- Reset then Start, Inst=9'b0010_00011 (ADD): InstLoad in cycle 1, Reg0Write=GenPurpRegWrite=1 only in cycle 4, PcEn=1 in cycle 4, InstCount=1.
- LOAD (9'b1110_00010) with MemReady asserted on the 3rd MEM cycle: MemReq high 3 cycles, WriteMem=0, WB with MemToReg=1, PcEn once, 7 cycles total.
- BLT (9'b1011_00001) with BranchTaken=1, then again with BranchTaken=0: PcEn=1/PcSrc=1 in EXEC, then PcEn=1/PcSrc=0; no register or memory strobes.
- STORE with MemReady held low, MEM_TIMEOUT=8: MemReq high 9 cycles, then HALTED with Fault=1, no PcEn, InstCount unchanged. Repeat with MemReady on cycle 9: no fault.
- HALT (9'b1111_00000) after 3 ADDs: Done=1, InstCount=3. Start=1 gives FETCH next cycle, Done=0, InstCount stays 3.
- Reset_n=0 during a MEM wait: next cycle in IDLE, MemReq=0, InstCount=0, all strobes 0. CNT_W=2 and 5 retires gives InstCount=1.
